mult_err_monitor: RTL

Streaming error-characterisation stage that sits directly downstream of the 8x8 approximate multipliers in the library. It consumes one operand pair plus the approximate product per accepted beat and recomputes the exact product internally. Over a run of 2^LOG2_SAMPLES samples it accumulates error distance (ED) statistics: sum, maximum, non-zero-error count and mean ED. It is the bench-and-silicon hook the team uses to rank multiplier variants.

---
 rtl/mult_err_pkg.sv | 31 +++
 rtl/mult_err_monitor_ed_calc.sv | 31 +++
 rtl/mult_err_monitor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_err_pkg.sv
// Shared definitions for the approximate-multiplier error monitor:
// datapath widths, FSM state encoding and the error-distance helper.
package mult_err_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;
  localparam int ED_W   = 16;
  localparam int SQ_W   = 2 * ED_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Magnitude of (exact - approx) formed as a 17-bit signed difference.
  function automatic logic [ED_W-1:0] abs_diff(
    input logic [PROD_W-1:0] exact,
    input logic [PROD_W-1:0] approx
  );
    logic [PROD_W:0] diff;
    diff = {1'b0, exact} - {1'b0, approx};
    if (diff[PROD_W]) begin
      abs_diff = {ED_W{1'b0}} - diff[ED_W-1:0];
    end else begin
      abs_diff = diff[ED_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mult_err_monitor_ed_calc.sv
// Combinational error-distance unit: exact 8x8 product, |exact - approx|
// and, when MERR_SQ_EN is defined, the 16x16 square of the error distance.
module ed_calc
  import mult_err_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] r_approx,
  output logic [ED_W-1:0]   ed
`ifdef MERR_SQ_EN
  ,
  output logic [SQ_W-1:0]   ed_sq
`endif
);

  logic [PROD_W-1:0] w_exact;

  // Exact product and its distance from the approximate result.
  always_comb begin
    w_exact = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
    ed      = abs_diff(w_exact, r_approx);
  end

`ifdef MERR_SQ_EN
  // Full-width square of the error distance for the MSE accumulator.
  always_comb begin
    ed_sq = {{ED_W{1'b0}}, ed} * {{ED_W{1'b0}}, ed};
  end
`endif

endmodule

// File: rtl/mult_err_monitor.sv
// Streaming error-distance statistics over 2^LOG2_SAMPLES samples.
// Optional feature macro: MERR_SQ_EN adds the ed_sq_sum accumulator.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int LOG2_SAMPLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            a,
  input  logic [OP_W-1:0]            b,
  input  logic [PROD_W-1:0]          r_approx,
  output logic                       busy,
  output logic                       done,
  output logic [ED_W+LOG2_SAMPLES-1:0] ed_sum,
  output logic [ED_W-1:0]            ed_max,
  output logic [LOG2_SAMPLES:0]      err_count,
  output logic [ED_W-1:0]            ed_mean
`ifdef MERR_SQ_EN
  ,
  output logic [SQ_W+LOG2_SAMPLES-1:0] ed_sq_sum
`endif
);

  localparam logic [LOG2_SAMPLES:0] LAST_CNT = {1'b0, {LOG2_SAMPLES{1'b1}}};

  state_e                        r_state;
  state_e                        w_state_nxt;
  logic [LOG2_SAMPLES:0]         r_cnt;
  logic                          r_drain;
  logic                          w_accept;
  logic                          w_clear;
  logic [ED_W-1:0]               w_ed;
  logic                          r_s1_valid;
  logic [ED_W-1:0]               r_s1_ed;
  logic [ED_W+LOG2_SAMPLES-1:0]  r_ed_sum;
  logic [ED_W-1:0]               r_ed_max;
  logic [LOG2_SAMPLES:0]         r_err_count;
`ifdef MERR_SQ_EN
  logic [SQ_W-1:0]               w_ed_sq;
  logic [SQ_W-1:0]               r_s1_sq;
  logic [SQ_W+LOG2_SAMPLES-1:0]  r_ed_sq_sum;
`endif

  ed_calc u_ed_calc (
    .a        (a),
    .b        (b),
    .r_approx (r_approx),
    .ed       (w_ed)
`ifdef MERR_SQ_EN
    ,
    .ed_sq    (w_ed_sq)
`endif
  );

  assign w_accept = in_valid && (r_state == RUN);
  assign w_clear  = start && (r_state == IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; DRAIN lasts two cycles to flush S1 and S2.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_accept && (r_cnt == LAST_CNT)) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (r_drain) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b0;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Sample counter and drain-cycle tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= {(LOG2_SAMPLES+1){1'b0}};
      r_drain <= 1'b0;
    end else begin
      if (w_clear) begin
        r_cnt <= {(LOG2_SAMPLES+1){1'b0}};
      end else if (w_accept) begin
        r_cnt <= r_cnt + {{LOG2_SAMPLES{1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      if (r_state == DRAIN) begin
        r_drain <= ~r_drain;
      end else begin
        r_drain <= 1'b0;
      end
    end
  end

  // S1: register the error distance of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ed    <= {ED_W{1'b0}};
`ifdef MERR_SQ_EN
      r_s1_sq    <= {SQ_W{1'b0}};
`endif
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ed <= w_ed;
`ifdef MERR_SQ_EN
        r_s1_sq <= w_ed_sq;
`endif
      end else begin
        r_s1_ed <= r_s1_ed;
`ifdef MERR_SQ_EN
        r_s1_sq <= r_s1_sq;
`endif
      end
    end
  end

  // S2: statistics accumulators; they hold in IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ed_sum    <= {(ED_W+LOG2_SAMPLES){1'b0}};
      r_ed_max    <= {ED_W{1'b0}};
      r_err_count <= {(LOG2_SAMPLES+1){1'b0}};
`ifdef MERR_SQ_EN
      r_ed_sq_sum <= {(SQ_W+LOG2_SAMPLES){1'b0}};
`endif
    end else if (w_clear) begin
      r_ed_sum    <= {(ED_W+LOG2_SAMPLES){1'b0}};
      r_ed_max    <= {ED_W{1'b0}};
      r_err_count <= {(LOG2_SAMPLES+1){1'b0}};
`ifdef MERR_SQ_EN
      r_ed_sq_sum <= {(SQ_W+LOG2_SAMPLES){1'b0}};
`endif
    end else if (r_s1_valid) begin
      r_ed_sum    <= r_ed_sum + {{LOG2_SAMPLES{1'b0}}, r_s1_ed};
      r_ed_max    <= (r_s1_ed > r_ed_max) ? r_s1_ed : r_ed_max;
      r_err_count <= r_err_count + {{LOG2_SAMPLES{1'b0}}, (r_s1_ed != {ED_W{1'b0}})};
`ifdef MERR_SQ_EN
      r_ed_sq_sum <= r_ed_sq_sum + {{LOG2_SAMPLES{1'b0}}, r_s1_sq};
`endif
    end else begin
      r_ed_sum    <= r_ed_sum;
      r_ed_max    <= r_ed_max;
      r_err_count <= r_err_count;
`ifdef MERR_SQ_EN
      r_ed_sq_sum <= r_ed_sq_sum;
`endif
    end
  end

  assign ed_sum    = r_ed_sum;
  assign ed_max    = r_ed_max;
  assign err_count = r_err_count;
  // Mean is the truncating shift of the sum by the run length exponent.
  assign ed_mean   = r_ed_sum[LOG2_SAMPLES +: ED_W];
`ifdef MERR_SQ_EN
  assign ed_sq_sum = r_ed_sq_sum;
`endif

endmodule
